// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding,
// status bytes sent back to the host, and the length-header size.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        ACK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } boot_state_t;

    localparam logic [7:0] ACK_OK    = 8'hAA;
    localparam logic [7:0] ACK_ERR   = 8'hEE;
    localparam int         LEN_BYTES = 4;

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: shifts received bytes MSB-first into a word and
// emits a one-cycle word_valid pulse in the cycle after the completing byte.
module boot_word_asm #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_byte_en,
    input  logic [7:0]            i_byte,
    output logic                  o_last,
    output logic                  o_word_valid,
    output logic [WORD_WIDTH-1:0] o_word
);
    localparam int BPW = WORD_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         r_cnt;
    logic                  r_word_valid;
    logic [WORD_WIDTH-1:0] r_word;

    // The byte currently being offered completes a word when the counter is at its last slot
    assign o_last       = (r_cnt == CW'(BPW - 1));
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // Shift register, byte counter and word-complete pulse
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= i_byte_en && o_last;
            if (i_byte_en) begin
                r_word <= WORD_WIDTH'({r_word, i_byte});
                r_cnt  <= o_last ? '0 : (r_cnt + CW'(1));
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot sequencer: receives a length-prefixed big-endian image, writes it
// to instruction memory, acknowledges with a status byte, then releases the
// core and hands the UART over to it.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte).
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int INST_WIDTH = 16,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic                  imem_we,
    output logic [INST_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  core_rst,
    output logic                  uart_sel,
    output logic                  boot_done,
    output logic                  boot_err
);
    localparam logic [32:0] MAX_WORDS = 33'd1 << INST_WIDTH;

    boot_state_t           r_state;
    boot_state_t           w_state_next;
    logic                  r_ok;
    logic                  w_ok_next;
    logic [23:0]           r_len;
    logic [1:0]            r_len_cnt;
    logic [INST_WIDTH:0]   r_nwords;
    logic [INST_WIDTH:0]   r_widx;
    logic [INST_WIDTH-1:0] r_addr;
    logic [31:0]           w_len_full;
    logic                  w_accept;
    logic                  w_asm_en;
    logic                  w_last;
    logic                  w_word_done;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic                  r_core_rst;
    logic                  r_uart_sel;
    logic                  r_boot_done;
    logic                  r_boot_err;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    // A byte coinciding with a restart pulse is discarded
    assign w_accept    = rx_valid && !boot_start;
    assign w_asm_en    = w_accept && (r_state == DATA);
    assign w_word_done = w_asm_en && w_last;
    assign w_len_full  = {r_len, rx_data};

    boot_word_asm #(.WORD_WIDTH(WORD_WIDTH)) u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (boot_start),
        .i_byte_en    (w_asm_en),
        .i_byte       (rx_data),
        .o_last       (w_last),
        .o_word_valid (imem_we),
        .o_word       (imem_wdata)
    );

    // FSM state and status flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LEN;
            r_ok    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_ok    <= w_ok_next;
        end
    end

    // Next-state and status decision
    always_comb begin
        w_state_next = r_state;
        w_ok_next    = r_ok;
        if (boot_start) begin
            w_state_next = LEN;
            w_ok_next    = 1'b1;
        end else begin
            case (r_state)
                LEN: begin
                    if (w_accept && (r_len_cnt == 2'(LEN_BYTES - 1))) begin
                        if (w_len_full == 32'd0) begin
                            w_ok_next = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            w_state_next = CSUM;
`else
                            w_state_next = ACK;
`endif
                        end else if ({1'b0, w_len_full} > MAX_WORDS) begin
                            w_ok_next    = 1'b0;
                            w_state_next = ACK;
                        end else begin
                            w_ok_next    = 1'b1;
                            w_state_next = DATA;
                        end
                    end else begin
                        w_state_next = LEN;
                    end
                end
                DATA: begin
                    if (w_word_done && (r_widx == (r_nwords - (INST_WIDTH+1)'(1)))) begin
`ifdef BOOT_CHECKSUM_EN
                        w_state_next = CSUM;
`else
                        w_state_next = ACK;
`endif
                    end else begin
                        w_state_next = DATA;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CSUM: begin
                    if (w_accept) begin
                        w_ok_next    = (rx_data == r_csum);
                        w_state_next = ACK;
                    end else begin
                        w_state_next = CSUM;
                    end
                end
`endif
                ACK: begin
                    // tx_valid is high for the whole of ACK, so tx_ready alone completes the transfer
                    if (tx_ready) begin
                        w_state_next = r_ok ? DONE : ERR;
                    end else begin
                        w_state_next = ACK;
                    end
                end
                DONE:    w_state_next = DONE;
                ERR:     w_state_next = ERR;
                default: w_state_next = LEN;
            endcase
        end
    end

    // Length header, word index and running checksum
    always_ff @(posedge clk) begin
        if (rst || boot_start) begin
            r_len     <= 24'd0;
            r_len_cnt <= 2'd0;
            r_nwords  <= '0;
            r_widx    <= '0;
            r_addr    <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            if (w_accept && (r_state == LEN)) begin
                r_len     <= w_len_full[23:0];
                r_len_cnt <= r_len_cnt + 2'd1;
                r_nwords  <= w_len_full[INST_WIDTH:0];
            end
            if (w_word_done) begin
                r_addr <= r_widx[INST_WIDTH-1:0];
                r_widx <= r_widx + (INST_WIDTH+1)'(1);
            end
`ifdef BOOT_CHECKSUM_EN
            if (w_asm_en) begin
                r_csum <= r_csum ^ rx_data;
            end
`endif
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_core_rst  <= 1'b1;
            r_uart_sel  <= 1'b0;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_tx_valid  <= (w_state_next == ACK);
            r_tx_data   <= (w_state_next == ACK) ? (w_ok_next ? ACK_OK : ACK_ERR) : 8'h00;
            r_core_rst  <= (w_state_next != DONE);
            r_uart_sel  <= (w_state_next == DONE);
            r_boot_done <= (w_state_next == DONE);
            r_boot_err  <= (w_state_next == ERR);
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign imem_addr = r_addr;
    assign core_rst  = r_core_rst;
    assign uart_sel  = r_uart_sel;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;

endmodule
